// File: rtl/alu_op_arbiter_pkg.sv
// Shared opcode constants and FSM state encoding for the ALU operation arbiter.
package alu_op_arbiter_pkg;

    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_SUB     = 3'b001;
    localparam logic [2:0] OP_AND     = 3'b010;
    localparam logic [2:0] OP_TWOSCOM = 3'b011;
    localparam logic [2:0] OP_OR      = 3'b100;
    localparam logic [2:0] OP_XOR     = 3'b101;
    localparam logic [2:0] OP_RL      = 3'b110;
    localparam logic [2:0] OP_RR      = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arb_state_e;

endpackage

// File: rtl/alu_rr_arbiter2.sv
// Two-input round-robin grant. The last-grant register starts at 1 so that
// requester 0 wins the first tie.
module alu_rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o
);

    logic       last_gnt_q;
    logic [1:0] gnt_s;

    // Grant the sole requester, or the one not served last on a tie.
    always_comb begin
        gnt_s = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_s = 2'b01;
                2'b10:   gnt_s = 2'b10;
                2'b11:   gnt_s = last_gnt_q ? 2'b01 : 2'b10;
                default: gnt_s = 2'b00;
            endcase
        end else begin
            gnt_s = 2'b00;
        end
    end

    assign gnt_o    = gnt_s;
    assign gnt_id_o = gnt_s[1];

    // Remember who was served on each accepted handshake.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            last_gnt_q <= 1'b1;
        end else if (upd_i) begin
            last_gnt_q <= gnt_s[1];
        end else begin
            last_gnt_q <= last_gnt_q;
        end
    end

endmodule

// File: rtl/alu_op_arbiter.sv
// Sequences two requesters onto the shared ALU datapath: IDLE -> EXEC -> RESP.
// Optional result flags (RspZero, RspOpEcho) are built when ALU_ARB_FLAGS_EN is defined.
module alu_op_arbiter
    import alu_op_arbiter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Req0Valid,
    output logic             Req0Ready,
    input  logic [2:0]       Req0Op,
    input  logic [WIDTH-1:0] Req0A,
    input  logic [WIDTH-1:0] Req0B,
    input  logic             Req1Valid,
    output logic             Req1Ready,
    input  logic [2:0]       Req1Op,
    input  logic [WIDTH-1:0] Req1A,
    input  logic [WIDTH-1:0] Req1B,
    output logic [2:0]       AluSel,
    output logic [WIDTH-1:0] AluA,
    output logic [WIDTH-1:0] AluB,
    input  logic [WIDTH-1:0] AluResult,
    output logic             RspValid,
    input  logic             RspReady,
    output logic [WIDTH-1:0] RspData,
    output logic             RspId
`ifdef ALU_ARB_FLAGS_EN
    ,
    output logic             RspZero,
    output logic [2:0]       RspOpEcho
`endif
);

    arb_state_e       state_q;
    logic [2:0]       sel_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             id_q;
`ifdef ALU_ARB_FLAGS_EN
    logic             zero_q;
    logic [2:0]       echo_q;
`endif

    logic             arb_en_s;
    logic             accept_s;
    logic [1:0]       gnt_s;
    logic             win_id_s;
    logic [2:0]       win_op_s;
    logic [WIDTH-1:0] win_a_s;
    logic [WIDTH-1:0] win_b_s;

    // Readiness is withheld while reset is held, even if the state already reads IDLE.
    assign arb_en_s = Rst_n && (state_q == ST_IDLE);
    assign accept_s = |gnt_s;

    alu_rr_arbiter2 u_rr (
        .clk_i    (Clk),
        .rst_n_i  (Rst_n),
        .en_i     (arb_en_s),
        .req_i    ({Req1Valid, Req0Valid}),
        .upd_i    (accept_s),
        .gnt_o    (gnt_s),
        .gnt_id_o (win_id_s)
    );

    // Route the winner's operation toward the datapath registers.
    always_comb begin
        win_op_s = Req0Op;
        win_a_s  = Req0A;
        win_b_s  = Req0B;
        if (win_id_s) begin
            win_op_s = Req1Op;
            win_a_s  = Req1A;
            win_b_s  = Req1B;
        end else begin
            win_op_s = Req0Op;
            win_a_s  = Req0A;
            win_b_s  = Req0B;
        end
    end

    // Control FSM with the datapath and response registers it owns.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= OP_ADD;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            data_q  <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
            id_q    <= 1'b0;
`ifdef ALU_ARB_FLAGS_EN
            zero_q  <= 1'b0;
            echo_q  <= 3'b000;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        sel_q   <= win_op_s;
                        a_q     <= win_a_s;
                        b_q     <= win_b_s;
                        id_q    <= win_id_s;
                        state_q <= ST_EXEC;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    data_q  <= AluResult;
                    valid_q <= 1'b1;
`ifdef ALU_ARB_FLAGS_EN
                    zero_q  <= (AluResult == {WIDTH{1'b0}});
                    echo_q  <= sel_q;
`endif
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    if (RspReady) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_RESP;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Req0Ready = gnt_s[0];
    assign Req1Ready = gnt_s[1];
    assign AluSel    = sel_q;
    assign AluA      = a_q;
    assign AluB      = b_q;
    assign RspValid  = valid_q;
    assign RspData   = data_q;
    assign RspId     = id_q;
`ifdef ALU_ARB_FLAGS_EN
    assign RspZero   = zero_q;
    assign RspOpEcho = echo_q;
`endif

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Directed bench for alu_op_arbiter with a behavioural model of the function units.
module tb_alu_op_arbiter;

    localparam int W = 4;

    logic         Clk = 1'b0;
    logic         Rst_n;
    logic         Req0Valid, Req1Valid;
    logic         Req0Ready, Req1Ready;
    logic [2:0]   Req0Op, Req1Op;
    logic [W-1:0] Req0A, Req0B, Req1A, Req1B;
    logic [2:0]   AluSel;
    logic [W-1:0] AluA, AluB, AluResult;
    logic         RspValid, RspReady, RspId;
    logic [W-1:0] RspData;
`ifdef ALU_ARB_FLAGS_EN
    logic         RspZero;
    logic [2:0]   RspOpEcho;
`endif

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    alu_op_arbiter #(.WIDTH(W)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Op(Req0Op), .Req0A(Req0A), .Req0B(Req0B),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Op(Req1Op), .Req1A(Req1A), .Req1B(Req1B),
        .AluSel(AluSel), .AluA(AluA), .AluB(AluB), .AluResult(AluResult),
        .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData), .RspId(RspId)
`ifdef ALU_ARB_FLAGS_EN
        , .RspZero(RspZero), .RspOpEcho(RspOpEcho)
`endif
    );

    // Function units plus select mux.
    always_comb begin
        case (AluSel)
            3'b000:  AluResult = AluA + AluB;
            3'b001:  AluResult = AluA - AluB;
            3'b010:  AluResult = AluA & AluB;
            3'b011:  AluResult = ~AluA + 4'd1;
            3'b100:  AluResult = AluA | AluB;
            3'b101:  AluResult = AluA ^ AluB;
            3'b110:  AluResult = {AluA[2:0], AluA[3]};
            3'b111:  AluResult = {AluA[0], AluA[3:1]};
            default: AluResult = 4'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (RspValid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("rsp_timeout", {7'd0, got}, 8'd1);
    endtask

    initial begin
        Rst_n = 1'b0; RspReady = 1'b0;
        Req0Valid = 1'b1; Req0Op = 3'b000; Req0A = 4'd0; Req0B = 4'd0;
        Req1Valid = 1'b0; Req1Op = 3'b000; Req1A = 4'd0; Req1B = 4'd0;
        repeat (2) @(negedge Clk);
        #1;
        chk("rst_ready0", {7'd0, Req0Ready}, 8'd0);
        chk("rst_valid", {7'd0, RspValid}, 8'd0);
        chk("rst_sel", {5'd0, AluSel}, 8'd0);
        chk("rst_a", {4'd0, AluA}, 8'd0);
        chk("rst_b", {4'd0, AluB}, 8'd0);
        chk("rst_data", {4'd0, RspData}, 8'd0);
        chk("rst_id", {7'd0, RspId}, 8'd0);
`ifdef ALU_ARB_FLAGS_EN
        chk("rst_zero", {7'd0, RspZero}, 8'd0);
        chk("rst_echo", {5'd0, RspOpEcho}, 8'd0);
`endif

        // Single requester add: 3 + 5
        Rst_n = 1'b1; Req0A = 4'd3; Req0B = 4'd5; RspReady = 1'b1;
        #1;
        chk("add_ready0", {7'd0, Req0Ready}, 8'd1);
        chk("add_ready1", {7'd0, Req1Ready}, 8'd0);
        @(negedge Clk);
        chk("exec_ready0", {7'd0, Req0Ready}, 8'd0);
        Req0Valid = 1'b0;
        chk("exec_sel", {5'd0, AluSel}, 8'd0);
        chk("exec_a", {4'd0, AluA}, 8'd3);
        chk("exec_b", {4'd0, AluB}, 8'd5);
        chk("exec_valid", {7'd0, RspValid}, 8'd0);
        @(negedge Clk);
        chk("add_valid", {7'd0, RspValid}, 8'd1);
        chk("add_data", {4'd0, RspData}, 8'd8);
        chk("add_id", {7'd0, RspId}, 8'd0);
        @(negedge Clk);
        chk("add_done", {7'd0, RspValid}, 8'd0);
        chk("idle_hold_a", {4'd0, AluA}, 8'd3);

        // Tie from reset, round robin: C & A = 8
        Rst_n = 1'b0;
        Req0Valid = 1'b1; Req0Op = 3'b010; Req0A = 4'hC; Req0B = 4'hA;
        Req1Valid = 1'b1; Req1Op = 3'b010; Req1A = 4'hC; Req1B = 4'hA;
        #1;
        chk("rst_tie_r0", {7'd0, Req0Ready}, 8'd0);
        chk("rst_tie_r1", {7'd0, Req1Ready}, 8'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        chk("tie_r0", {7'd0, Req0Ready}, 8'd1);
        chk("tie_r1", {7'd0, Req1Ready}, 8'd0);
        wait_rsp();
        chk("rr1_id", {7'd0, RspId}, 8'd0);
        chk("rr1_data", {4'd0, RspData}, 8'd8);
        wait_rsp();
        chk("rr2_id", {7'd0, RspId}, 8'd1);
        chk("rr2_data", {4'd0, RspData}, 8'd8);
        wait_rsp();
        chk("rr3_id", {7'd0, RspId}, 8'd0);
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        @(negedge Clk);

        // Backpressure: 7 - 2 from requester 1
        RspReady = 1'b0;
        Req1Valid = 1'b1; Req1Op = 3'b001; Req1A = 4'd7; Req1B = 4'd2;
        wait_rsp();
        Req0Valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", {7'd0, RspValid}, 8'd1);
            chk("bp_data", {4'd0, RspData}, 8'd5);
            chk("bp_id", {7'd0, RspId}, 8'd1);
            chk("bp_ready", {6'd0, Req1Ready, Req0Ready}, 8'd0);
            @(negedge Clk);
        end
        RspReady = 1'b1; Req0Valid = 1'b0; Req1Valid = 1'b0;
        @(negedge Clk);
        chk("bp_release", {7'd0, RspValid}, 8'd0);
        Req0Valid = 1'b1;
        #1;
        chk("bp_idle", {7'd0, Req0Ready}, 8'd1);
        Req0Valid = 1'b0;
        @(negedge Clk);

        // Wrap-around: F + 1, then 2 ^ 1
        Req0Valid = 1'b1; Req0Op = 3'b000; Req0A = 4'hF; Req0B = 4'd1;
        @(negedge Clk);
        Req0Valid = 1'b0;
        wait_rsp();
        chk("wrap_data", {4'd0, RspData}, 8'd0);
`ifdef ALU_ARB_FLAGS_EN
        chk("wrap_zero", {7'd0, RspZero}, 8'd1);
        chk("wrap_echo", {5'd0, RspOpEcho}, 8'd0);
`endif
        @(negedge Clk);
        Req0Valid = 1'b1; Req0Op = 3'b101; Req0A = 4'd2; Req0B = 4'd1;
        @(negedge Clk);
        Req0Valid = 1'b0;
        wait_rsp();
        chk("xor_data", {4'd0, RspData}, 8'd3);
`ifdef ALU_ARB_FLAGS_EN
        chk("xor_zero", {7'd0, RspZero}, 8'd0);
        chk("xor_echo", {5'd0, RspOpEcho}, 8'd5);
`endif
        @(negedge Clk);

        // Reset during EXEC of a rotate-left
        Req0Valid = 1'b1; Req0Op = 3'b110; Req0A = 4'd1; Req0B = 4'd0;
        @(negedge Clk);
        Req0Valid = 1'b0; Rst_n = 1'b0;
        @(negedge Clk);
        chk("abort_valid", {7'd0, RspValid}, 8'd0);
        chk("abort_sel", {5'd0, AluSel}, 8'd0);
        chk("abort_a", {4'd0, AluA}, 8'd0);
        Req0Valid = 1'b1; Req0Op = 3'b000; Req0A = 4'd1; Req0B = 4'd1;
        Req1Valid = 1'b1; Req1Op = 3'b000; Req1A = 4'd1; Req1B = 4'd1;
        #1;
        chk("rstlow_ready", {6'd0, Req1Ready, Req0Ready}, 8'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        chk("post_rst_r0", {7'd0, Req0Ready}, 8'd1);
        chk("post_rst_r1", {7'd0, Req1Ready}, 8'd0);
        @(negedge Clk);
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        wait_rsp();
        chk("post_rst_id", {7'd0, RspId}, 8'd0);
        chk("post_rst_data", {4'd0, RspData}, 8'd2);
        @(negedge Clk);

        // Late valid from requester 1 during RESP
        RspReady = 1'b0;
        Req0Valid = 1'b1; Req0Op = 3'b100; Req0A = 4'd5; Req0B = 4'd2;
        @(negedge Clk);
        Req0Valid = 1'b0;
        wait_rsp();
        chk("or_data", {4'd0, RspData}, 8'd7);
        Req1Valid = 1'b1; Req1Op = 3'b011; Req1A = 4'd1; Req1B = 4'd0;
        #1;
        chk("late_r1_a", {7'd0, Req1Ready}, 8'd0);
        @(negedge Clk);
        chk("late_valid", {7'd0, RspValid}, 8'd1);
        chk("late_r1_b", {7'd0, Req1Ready}, 8'd0);
        RspReady = 1'b1;
        #1;
        chk("late_r1_hs", {7'd0, Req1Ready}, 8'd0);
        @(negedge Clk);
        #1;
        chk("late_rsp_clr", {7'd0, RspValid}, 8'd0);
        chk("late_r1_gnt", {7'd0, Req1Ready}, 8'd1);
        @(negedge Clk);
        Req1Valid = 1'b0;
        wait_rsp();
        chk("neg_data", {4'd0, RspData}, 8'hF);
        chk("neg_id", {7'd0, RspId}, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
